spi_master_ctrl: RTL and testbench

Single-channel SPI master controller that sequences 9-bit frames toward spi-slave devices in this codebase. Each frame is one read/write flag bit followed by 8 data bits, LSB first, on mosi. Accepts byte commands over a valid/ready handshake, derives sclk from the system clock, drives cs/mosi, captures read data from miso, and returns a one-cycle response. It sits between the on-chip command source (bus bridge or test sequencer) and the SPI pins.

---
 rtl/spi_master_ctrl.sv | 115 +++++++++++
 tb/tb_spi_master_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master sending 9-bit frames (rd/wr flag then 8 data bits, LSB first)
module spi_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] SHIFT_HI = 3'd2;
    localparam logic [2:0] SHIFT_LO = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;
    localparam logic [2:0] GAP      = 3'd6;
    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic          rd_q, rd_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          rsp_q, rsp_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          last;
    // Frame sequencing; pin values are computed from the next state so the pins come straight from flops
    always_comb begin
        last    = div_q == DIV_LAST;
        state_d = state_q;
        bit_d   = bit_q;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        rx_d    = rx_q;
        mosi_d  = mosi_q;
        rdata_d = (state_q == DONE && rd_q) ? rx_q : rdata_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SETUP;
                    rd_d    = cmd_rd;
                    wdata_d = cmd_wdata;
                    bit_d   = '0;
                    mosi_d  = cmd_rd;
                end
            end
            SETUP:    state_d = last ? SHIFT_HI : state_q;
            SHIFT_HI: begin
                if (last) begin
                    state_d = (bit_q == 4'd8) ? HOLD : SHIFT_LO;
                    bit_d   = bit_q + 4'd1;
                    mosi_d  = (rd_q || bit_q == 4'd8) ? 1'b0 : wdata_q[bit_q[2:0]];
                    if (rd_q && bit_q != 4'd8) rx_d[bit_q[2:0]] = miso;
                end
            end
            SHIFT_LO: state_d = last ? SHIFT_HI : state_q;
            HOLD:     state_d = last ? DONE : state_q;
            DONE:     state_d = GAP;
            GAP:      state_d = last ? IDLE : state_q;
            default:  state_d = IDLE;
        endcase
        div_d  = (state_d != state_q || state_q == IDLE) ? '0 : div_q + DW'(1);
        cs_d   = state_d == IDLE || state_d == DONE || state_d == GAP;
        sclk_d = state_d == SHIFT_HI;
        rsp_d  = state_q == DONE;
    end
    // State and pin registers; reset aborts any frame immediately
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            rsp_q   <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end
    assign cmd_ready = state_q == IDLE && !i_reset;
    assign busy      = state_q != IDLE;
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign cs        = cs_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: scoreboard bench for spi_master_ctrl at CLK_DIV=2 and CLK_DIV=1 with a slave model
module tb_spi_master_ctrl;
    typedef struct {
        int         inst;
        bit         rd;
        logic [7:0] rdata;
        logic [7:0] dout;
        logic [8:0] bits;
    } exp_t;
    logic       clk = 1'b0;
    logic [1:0] i_reset;
    logic [1:0] cmd_valid;
    logic [1:0] cmd_rd;
    logic [7:0] cmd_wdata [2];
    wire  [1:0] cmd_ready, rsp_valid, busy, sclk, cs, mosi;
    wire  [7:0] rsp_rdata [2];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       sb[$];
    logic [7:0] mem [2];
    logic [7:0] last_rd [2];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int D = (g == 0) ? 2 : 1;
        logic       miso = 1'b0;
        logic       rw = 1'b0;
        logic [3:0] ecnt = '0;
        logic [7:0] sh = '0;
        logic [7:0] dout = '0;
        logic [8:0] frame = '0;
        int         tot = 0;
        int         viol = 0;
        int         acc_edge = 0;
        int         cs_lo = 0;
        int         cs_hi = 0;
        int         tot0 = 0;
        int         viol0 = 0;
        bit         prev_rdy = 1'b0;
        bit         rdy_pend = 1'b0;
        bit         seen = 1'b0;
        exp_t       e;
        spi_master_ctrl #(.CLK_DIV(D)) u_dut (
            .clk      (clk),
            .i_reset  (i_reset[g]),
            .cmd_valid(cmd_valid[g]),
            .cmd_ready(cmd_ready[g]),
            .cmd_rd   (cmd_rd[g]),
            .cmd_wdata(cmd_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .busy     (busy[g]),
            .sclk     (sclk[g]),
            .cs       (cs[g]),
            .mosi     (mosi[g]),
            .miso     (miso)
        );
        // Slave: samples mosi on rising sclk, drives read bit k-1 after rising edge k
        always @(posedge sclk[g] or posedge i_reset[g]) begin
            if (i_reset[g]) begin
                ecnt = '0;
                dout = '0;
                miso = 1'b0;
            end else begin
                tot++;
                if (cs[g]) viol++;
                frame[ecnt] = mosi[g];
                if (ecnt == 4'd0) rw = mosi[g];
                else sh[3'(ecnt - 4'd1)] = mosi[g];
                miso = (rw && ecnt < 4'd8) ? dout[ecnt[2:0]] : 1'b0;
                if (ecnt == 4'd8 && !rw) dout = sh;
                ecnt = (ecnt == 4'd8) ? 4'd0 : ecnt + 4'd1;
            end
        end
        // Monitor: accept timing, cs windows and scoreboard comparison at each response
        always @(negedge clk) begin
            if (i_reset[g]) rdy_pend = 1'b0;
            if (cmd_ready[g] && !prev_rdy && rdy_pend) begin
                check("ready_latency", cyc - acc_edge, 20 * D + 1);
                rdy_pend = 1'b0;
            end
            prev_rdy = cmd_ready[g];
            if (cmd_valid[g] && cmd_ready[g]) begin
                if (seen) check("cs_gap_ge2", 32'(cs_hi >= 2), 1);
                seen     = 1'b1;
                acc_edge = cyc + 1;
                cs_lo    = 0;
                tot0     = tot;
                viol0    = viol;
                rdy_pend = 1'b1;
            end
            cs_lo += cs[g] ? 0 : 1;
            cs_hi = cs[g] ? cs_hi + 1 : 0;
            if (rsp_valid[g]) begin
                if (sb.size() == 0 || sb[0].inst != g) check("rsp_extra", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("rsp_latency", cyc - acc_edge, 19 * D + 1);
                    check("cs_low", cs_lo, 19 * D);
                    check("sclk_edges", tot - tot0, 9);
                    check("sclk_cs_high", viol - viol0, 0);
                    check("mosi_bits", 32'(frame), 32'(e.bits));
                    check("rsp_rdata", 32'(rsp_rdata[g]), 32'(e.rdata));
                    check("slave_dout", 32'(dout), 32'(e.dout));
                end
            end
        end
    end
    task automatic send(input int g, input bit rd, input logic [7:0] wd, input bit hold);
        int n = 0;
        cmd_valid[g] = 1'b1;
        cmd_rd[g]    = rd;
        cmd_wdata[g] = wd;
        while (!cmd_ready[g] && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) check("accept_timeout", 0, 1);
        else begin
            if (rd) last_rd[g] = mem[g];
            else mem[g] = wd;
            sb.push_back('{g, rd, last_rd[g], mem[g], rd ? 9'h001 : {wd, 1'b0}});
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid[g] = 1'b0;
    endtask
    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask
    initial begin
        int n;
        i_reset   = 2'b11;
        cmd_valid = 2'b00;
        cmd_rd    = 2'b00;
        cmd_wdata = '{8'h00, 8'h00};
        mem       = '{8'h00, 8'h00};
        last_rd   = '{8'h00, 8'h00};
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'(cs), 3);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_rsp", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdata", 32'(rsp_rdata[0]), 0);
        i_reset = 2'b00;
        #1;
        check("ready_release", 32'(cmd_ready), 3);
        @(posedge clk);
        #1;
        send(0, 1'b0, 8'hA5, 1'b0);
        wait_done();
        send(0, 1'b1, 8'h5A, 1'b0);
        wait_done();
        send(0, 1'b0, 8'h3C, 1'b1);
        send(0, 1'b1, 8'h00, 1'b0);
        wait_done();
        send(0, 1'b0, 8'h96, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        cmd_valid[0] = 1'b1;
        cmd_rd[0]    = 1'b1;
        cmd_wdata[0] = 8'h0F;
        check("busy_ready", 32'(cmd_ready[0]), 0);
        check("busy_flag", 32'(busy[0]), 1);
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        wait_done();
        send(0, 1'b1, 8'h00, 1'b0);
        wait_done();
        send(0, 1'b0, 8'hC3, 1'b0);
        n = 0;
        while (gi[0].ecnt != 4'd4 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_bit4", 32'(gi[0].ecnt), 4);
        i_reset[0] = 1'b1;
        #1;
        check("abort_cs", 32'(cs[0]), 1);
        check("abort_sclk", 32'(sclk[0]), 0);
        check("abort_mosi", 32'(mosi[0]), 0);
        check("abort_rsp", 32'(rsp_valid[0]), 0);
        check("abort_busy", 32'(busy[0]), 0);
        sb.delete();
        mem[0]     = 8'h00;
        last_rd[0] = 8'h00;
        @(posedge clk);
        #1;
        i_reset[0] = 1'b0;
        @(posedge clk);
        #1;
        send(0, 1'b0, 8'h81, 1'b0);
        wait_done();
        send(0, 1'b1, 8'h00, 1'b0);
        wait_done();
        send(1, 1'b0, 8'hFF, 1'b0);
        wait_done();
        send(1, 1'b1, 8'h00, 1'b0);
        wait_done();
        send(1, 1'b0, 8'h01, 1'b1);
        send(1, 1'b1, 8'h00, 1'b0);
        wait_done();
        for (int i = 0; i < 8; i++) begin
            send(i % 2, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
            wait_done();
        end
        repeat (50) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
